// File: rtl/display_bcd_writer.sv
// Converts a 16-bit binary value to four BCD digits (shift-and-add-3) and writes
// the digit codes into display frame-buffer slots 0..3 over an address/data/load port.
module display_bcd_writer #(
  parameter logic [4:0] BLANK_CODE = 5'h10,
  parameter logic [4:0] DASH_CODE  = 5'h11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [1:0]  wrAddress,
  output logic [15:0] wrData,
  output logic        wrLoad
);

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

  state_t      state;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        blank;
  logic [4:0]  cnt;
  logic [1:0]  slot;

  logic [15:0] bcd_lo_adj;
  logic [19:0] bcd_shift;

  // The top nibble never reaches 5 before the final shift (16-bit max is 65535),
  // so only the four low nibbles need the add-3 correction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bcd_lo_adj = bcd[15:0];
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_lo_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd[18:16], bcd_lo_adj, bin[15]};
  end

  function automatic logic [4:0] digit_code(input logic [19:0] b, input logic blank_en,
                                            input logic [1:0] k);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(k) && b[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (b[19:16] != 4'd0) return DASH_CODE;
    if (blank_en && k != 2'd0 && upper_zero) return BLANK_CODE;
    return {1'b0, b[4*k +: 4]};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      blank     <= 1'b0;
      cnt       <= '0;
      slot      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      wrLoad    <= 1'b0;
      wrAddress <= '0;
      wrData    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin      <= value;
            blank    <= blank_lz;
            bcd      <= '0;
            cnt      <= 5'd16;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd <= bcd_shift;
          bin <= {bin[14:0], 1'b0};
          cnt <= cnt - 5'd1;
          // Slot 0 is presented on the same edge the final digits become valid.
          if (cnt == 5'd1) begin
            state     <= WRITE;
            slot      <= 2'd0;
            wrLoad    <= 1'b1;
            wrAddress <= 2'd0;
            wrData    <= {11'b0, digit_code(bcd_shift, blank, 2'd0)};
            overflow  <= (bcd_shift[19:16] != 4'd0);
          end
        end
        WRITE: begin
          if (slot == 2'd3) begin
            wrLoad <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            slot      <= slot + 2'd1;
            wrAddress <= slot + 2'd1;
            wrData    <= {11'b0, digit_code(bcd, blank, slot + 2'd1)};
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_bcd_writer.sv
// Self-checking bench for display_bcd_writer: directed cases from the block's
// behaviour plus randomized values checked against a decimal-arithmetic model.
module tb_display_bcd_writer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] value;
  logic        blank_lz;
  logic        busy, done, overflow, wrLoad;
  logic [1:0]  wrAddress;
  logic [15:0] wrData;

  int n_checks = 0;
  int n_fail   = 0;

  display_bcd_writer dut (
    .CLK(CLK), .RST(RST), .start(start), .value(value), .blank_lz(blank_lz),
    .busy(busy), .done(done), .overflow(overflow),
    .wrAddress(wrAddress), .wrData(wrData), .wrLoad(wrLoad)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, leading-zero rule stated on digit positions.
  function automatic logic [4:0] ref_code(input int v, input bit bl, input int k);
    int digs[4];
    int top;
    int div;
    if (v > 9999) return 5'h11;
    div = 1;
    top = 0;
    for (int i = 0; i < 4; i++) begin
      digs[i] = (v / div) % 10;
      if (digs[i] != 0) top = i;
      div = div * 10;
    end
    if (bl && k > top) return 5'h10;
    return 5'(digs[k]);
  endfunction

  // One full conversion; optional stray starts at T+5 and in the DONE cycle T+21.
  task automatic do_conv(input int v, input bit bl, input bit stray);
    int loads = 0;
    int dones = 0;
    int busy_bad = 0;
    bit exp_ovf = (v > 9999);
    @(negedge CLK);
    value = 16'(v); blank_lz = bl; start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge CLK);
      start = stray && (c == 5 || c == 21);
      value = 16'($urandom_range(0, 65535));
      blank_lz = 1'($urandom_range(0, 1));
      if (wrLoad) loads++;
      if (done) dones++;
      if (c == 1) check("ovf_clear_on_start", 32'(overflow), 0);
      if (c <= 20 && !busy) busy_bad++;
      if (c >= 17 && c <= 20) begin
        check("wr_load", 32'(wrLoad), 1);
        check("wr_addr", 32'(wrAddress), 32'(c - 17));
        check($sformatf("wr_data v=%0d bl=%0d slot=%0d", v, bl, c - 17),
              32'(wrData), 32'(ref_code(v, bl, c - 17)));
        check("ovf_in_write", 32'(overflow), 32'(exp_ovf));
      end
      if (c == 21) begin
        check("done_pulse", 32'(done), 1);
        check("busy_in_done", 32'(busy), 0);
        check("ovf_hold", 32'(overflow), 32'(exp_ovf));
      end
      if (c == 22) check("idle_after_done", 32'(busy), 0);
    end
    check("load_count", 32'(loads), 4);
    check("done_count", 32'(dones), 1);
    check("busy_during_op", 32'(busy_bad), 0);
  endtask

  // Reset asserted so it is sampled at edge T+rc; expected_loads slots written before it.
  task automatic do_reset_run(input int v, input int rc, input int expected_loads);
    int loads = 0;
    int late = 0;
    @(negedge CLK);
    value = 16'(v); blank_lz = 1'b0; start = 1'b1;
    for (int c = 1; c <= rc; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (wrLoad) loads++;
      if (c == rc) RST = 1'b1;
    end
    @(negedge CLK);
    RST = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_load", 32'(wrLoad), 0);
    check("rst_addr", 32'(wrAddress), 0);
    check("rst_data", 32'(wrData), 0);
    check("loads_before_rst", 32'(loads), 32'(expected_loads));
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      if (wrLoad || busy || done) late++;
    end
    check("quiet_after_rst", 32'(late), 0);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; value = '0; blank_lz = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_ovf", 32'(overflow), 0);
    check("reset_load", 32'(wrLoad), 0);
    check("reset_addr", 32'(wrAddress), 0);
    check("reset_data", 32'(wrData), 0);
    RST = 1'b0;

    do_conv(1234, 1'b0, 1'b1);
    do_conv(42, 1'b1, 1'b0);
    do_conv(42, 1'b0, 1'b0);
    do_conv(0, 1'b1, 1'b0);
    do_conv(9999, 1'b0, 1'b0);
    do_conv(12345, 1'b1, 1'b0);
    do_conv(7, 1'b0, 1'b0);
    do_conv(10000, 1'b0, 1'b0);
    do_conv(65535, 1'b0, 1'b0);
    do_conv(100, 1'b1, 1'b0);

    do_reset_run(1234, 10, 0);
    do_reset_run(1234, 18, 2);
    do_conv(5678, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int v;
      v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      do_conv(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_bcd_writer.md
# display_bcd_writer

Upstream feeder for the 4-digit 7-segment display peripheral. It accepts a 16-bit binary value on a start/busy handshake and converts it to four decimal digits with a sequential shift-and-add-3 (double-dabble) engine. It then writes the digit codes into display frame-buffer slots 0 (LS) to 3 (MS) over the display's address/data/load write port. Optional leading-zero blanking and out-of-range indication are supported; the block never writes the decimal-point slot.

## Interface

Parameters:
- BLANK_CODE, 5'h10, digit code written for a blanked digit.
- DASH_CODE, 5'h11, digit code written to every digit on overflow.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  request a conversion; sampled only when idle.
- value  in  16  unsigned binary value; captured on the accepted start.
- blank_lz  in  1  leading-zero blank enable; captured with value.
- busy  out  1  high while a conversion or write sequence is in progress.
- done  out  1  single-cycle pulse after the last display write.
- overflow  out  1  captured value > 9999; holds until the next accepted start.
- wrAddress  out  2  display frame-buffer slot, driven to the display's address input.
- wrData  out  16  display data; [4:0] is the digit code, [15:5] is always 0.
- wrLoad  out  1  display write strobe; one slot written per high cycle.

## Operation

- State machine states: IDLE, CONVERT, WRITE, DONE.
- **IDLE**
  - When start=1, capture value and blank_lz, clear the 20-bit BCD accumulator, load the shift counter with 16, and go to CONVERT.
  - When start=0, stay in IDLE.
- **CONVERT** (16 cycles). Each cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {bcd, bin} left by one, taking the binary MSB into bcd[0].
  - Decrement the counter. When it reaches 0, go to WRITE with the slot index at 0.
- **Digit selection**, computed from the final BCD nibbles d0 (LS) to d4:
  - Overflow: if d4 != 0, all four written codes are DASH_CODE and overflow is set.
  - Blanking: otherwise, if blank_lz=1, digit k (k = 1..3) is BLANK_CODE when dk and all higher digits are 0. Digit 0 is never blanked, so value 0 displays "0".
  - Otherwise digit k is written as {1'b0, dk}.
- **WRITE** (4 cycles)
  - wrLoad=1, wrAddress = slot index, wrData = {11'b0, code(slot)}.
  - Slot index increments 0→1→2→3.
  - After slot 3, go to DONE.
- **DONE** (1 cycle): done=1, busy=0, then go to IDLE. A start sampled in the DONE cycle is ignored.
- start while busy is ignored; it is not queued.
- The overflow flag updates at the end of CONVERT and is cleared on the next accepted start.

## Timing

- **Reset values:** state=IDLE, busy=0, done=0, overflow=0, wrLoad=0, wrAddress=0, wrData=0.
- **Cycle numbering:** start is sampled high at edge T.
  - busy=1 from cycle T+1.
  - CONVERT occupies cycles T+1..T+16.
  - WRITE occupies cycles T+17..T+20, with wrLoad=1 and wrAddress=0,1,2,3 in that order.
  - DONE is cycle T+21: done=1, busy=0.
- **Latency:** start to done is 21 cycles. The earliest next accepted start is at edge T+22.
- The display latches wrData on the same rising edge that wrLoad is high. wrAddress and wrData are stable for the whole wrLoad cycle.
- wrLoad is 0 in every non-WRITE cycle. wrData and wrAddress may hold their last values while wrLoad=0.
- **Reset mid-operation:** RST=1 at any edge returns every output to its reset value on that edge. No further wrLoad pulses occur, and slots already written keep their data.
- RST has priority over start in the same cycle.

## Test plan

- value=1234, blank_lz=0 → wrLoad cycles T+17..T+20 write 4,3,2,1 to slots 0..3; done at T+21; overflow=0.
- value=42, blank_lz=1 → slots 0..3 receive 2, 4, 0x10, 0x10. The same value with blank_lz=0 → 2, 4, 0, 0.
- value=0, blank_lz=1 → 0, 0x10, 0x10, 0x10. value=9999 → 9,9,9,9, overflow=0.
- value=12345 → all four slots receive 0x11 and overflow=1. A following start with value=7 clears overflow on the start edge and writes 7,0,0,0.
- Start pulses at T+5 and at T+21 (DONE cycle) → both ignored; exactly 4 wrLoad pulses and 1 done pulse for the sequence.
- RST asserted at T+10 (mid-CONVERT) and, in a separate run, at T+18 (mid-WRITE) → all outputs 0 on the next cycle. In the mid-WRITE run only slots 0 and 1 are written. A fresh start afterwards completes normally.
